// File: rtl/ldo_trim_pkg.sv
// Shared constants, FSM state type and helpers for the LDO trim controller.
package ldo_trim_pkg;

  // Register offsets within the 256-byte Wishbone window
  localparam logic [7:0] OFS_TGT0   = 8'h00;
  localparam logic [7:0] OFS_TGT1   = 8'h04;
  localparam logic [7:0] OFS_TGT2   = 8'h08;
  localparam logic [7:0] OFS_STATUS = 8'h0C;
  localparam logic [7:0] OFS_CTRL   = 8'h10;
  localparam logic [7:0] OFS_IRQST  = 8'h14;

  // Power-on trim indices per channel
  localparam logic [3:0] RST_IDX0 = 4'd6;
  localparam logic [3:0] RST_IDX1 = 4'd8;
  localparam logic [3:0] RST_IDX2 = 4'd10;

  // Power-on prescaler divisor
  localparam logic [15:0] RST_DIV = 16'h00FF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } chan_state_e;

  // Replace only the bytes whose select bit is set
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ldo_trim_chan.sv
// One LDO trim channel: target/current index, ramp FSM and one-hot decode.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | current index equals target, no stepping
//   ST_RAMP | stepping current index one position per tick toward target;
//           | leaves (and pulses o_done) the cycle after current == target
module ldo_trim_chan
  import ldo_trim_pkg::*;
#(
  parameter logic [3:0] RST_IDX = 4'd0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tick,
  input  logic        i_tgt_we,
  input  logic [3:0]  i_tgt_d,
  output logic [3:0]  o_tgt,
  output logic [3:0]  o_cur,
  output logic [15:0] o_trim,
  output logic        o_busy,
  output logic        o_done
);

  chan_state_e r_state, w_state_nxt;
  logic [3:0]  r_tgt, r_cur, w_cur_nxt;
  logic        w_done;

  // State, target and current index registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_tgt   <= RST_IDX;
      r_cur   <= RST_IDX;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      if (i_tgt_we) r_tgt <= i_tgt_d;
    end
  end

  // Next state and step; direction is taken from the target at the tick,
  // so a retarget mid-ramp takes effect on the following step
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_cur != r_tgt) w_state_nxt = ST_RAMP;
      end
      ST_RAMP: begin
        if (r_cur == r_tgt) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
        end else if (i_tick) begin
          w_cur_nxt = (r_tgt > r_cur) ? r_cur + 4'd1 : r_cur - 4'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_tgt  = r_tgt;
  assign o_cur  = r_cur;
  assign o_trim = 16'(1) << r_cur;
  assign o_busy = (r_state == ST_RAMP);
  assign o_done = w_done;

endmodule

// File: rtl/ldo_trim_ctrl.sv
// LDO trim controller: Wishbone register file, shared ramp prescaler,
// ramp-done interrupt and three independent trim channels.
module ldo_trim_ctrl
  import ldo_trim_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          DIV_W    = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic [15:0] trim0_o,
  output logic [15:0] trim1_o,
  output logic [15:0] trim2_o,
  output logic [2:0]  busy_o,
  output logic        irq_o
);

  logic             r_ack;
  logic [31:0]      r_dat;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_pcnt;
  logic             r_irq_en;
  logic [2:0]       r_irqst;
  logic             r_irq;

  logic [7:0]  w_ofs;
  logic        w_hit, w_wr, w_ctrl_we, w_tick, w_irq_en_nxt;
  logic [2:0]  w_tgt_we, w_w1c, w_irqst_nxt, w_busy, w_done;
  logic [31:0] w_ctrl_cur, w_ctrl_new, w_rdata;
  logic [3:0]  w_tgt0, w_tgt1, w_tgt2, w_cur0, w_cur1, w_cur2;
  logic        w_unused_ctrl;

  // The ~r_ack term guarantees an idle cycle between acks
  assign w_ofs     = wbs_adr_i[7:0];
  assign w_hit     = wbs_cyc_i & wbs_stb_i & ~r_ack &
                     (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign w_wr      = w_hit & wbs_we_i;
  assign w_tgt_we  = {w_wr & wbs_sel_i[0] & (w_ofs == OFS_TGT2),
                      w_wr & wbs_sel_i[0] & (w_ofs == OFS_TGT1),
                      w_wr & wbs_sel_i[0] & (w_ofs == OFS_TGT0)};
  assign w_ctrl_we = w_wr & (|wbs_sel_i) & (w_ofs == OFS_CTRL);
  assign w_w1c     = (w_wr & wbs_sel_i[0] & (w_ofs == OFS_IRQST)) ?
                     wbs_dat_i[2:0] : 3'b000;

  assign w_ctrl_cur    = 32'(r_div) | {15'd0, r_irq_en, 16'd0};
  assign w_ctrl_new    = byte_merge(w_ctrl_cur, wbs_dat_i, wbs_sel_i);
  assign w_unused_ctrl = ^w_ctrl_new;
  assign w_irq_en_nxt  = w_ctrl_we ? w_ctrl_new[16] : r_irq_en;
  // A hardware set in the same cycle as a W1C clear wins
  assign w_irqst_nxt   = (r_irqst & ~w_w1c) | w_done;
  assign w_tick        = (r_pcnt == r_div);

  // Read-data mux; unmapped offsets read as zero
  always_comb begin
    w_rdata = 32'd0;
    case (w_ofs)
      OFS_TGT0:   w_rdata = {28'd0, w_tgt0};
      OFS_TGT1:   w_rdata = {28'd0, w_tgt1};
      OFS_TGT2:   w_rdata = {28'd0, w_tgt2};
      OFS_STATUS: w_rdata = {17'd0, w_busy, w_cur2, w_cur1, w_cur0};
      OFS_CTRL:   w_rdata = w_ctrl_cur;
      OFS_IRQST:  w_rdata = {29'd0, r_irqst};
      default:    w_rdata = 32'd0;
    endcase
  end

  // Single-cycle ack with read data present only in the ack cycle
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= 32'd0;
    end else begin
      r_ack <= w_hit;
      r_dat <= (w_hit & ~wbs_we_i) ? w_rdata : 32'd0;
    end
  end

  // Control, interrupt status and registered interrupt output
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_div    <= DIV_W'(RST_DIV);
      r_irq_en <= 1'b0;
      r_irqst  <= 3'b000;
      r_irq    <= 1'b0;
    end else begin
      if (w_ctrl_we) r_div <= w_ctrl_new[DIV_W-1:0];
      r_irq_en <= w_irq_en_nxt;
      r_irqst  <= w_irqst_nxt;
      r_irq    <= w_irq_en_nxt & (|w_irqst_nxt);
    end
  end

  // Free-running prescaler, tick every DIV+1 cycles, restarted by CTRL writes
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_pcnt <= '0;
    end else if (w_ctrl_we || w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + DIV_W'(1);
    end
  end

  ldo_trim_chan #(.RST_IDX(RST_IDX0)) u_chan0 (
    .i_clk(wb_clk_i), .i_rst(wb_rst_i), .i_tick(w_tick),
    .i_tgt_we(w_tgt_we[0]), .i_tgt_d(wbs_dat_i[3:0]),
    .o_tgt(w_tgt0), .o_cur(w_cur0), .o_trim(trim0_o),
    .o_busy(w_busy[0]), .o_done(w_done[0])
  );

  ldo_trim_chan #(.RST_IDX(RST_IDX1)) u_chan1 (
    .i_clk(wb_clk_i), .i_rst(wb_rst_i), .i_tick(w_tick),
    .i_tgt_we(w_tgt_we[1]), .i_tgt_d(wbs_dat_i[3:0]),
    .o_tgt(w_tgt1), .o_cur(w_cur1), .o_trim(trim1_o),
    .o_busy(w_busy[1]), .o_done(w_done[1])
  );

  ldo_trim_chan #(.RST_IDX(RST_IDX2)) u_chan2 (
    .i_clk(wb_clk_i), .i_rst(wb_rst_i), .i_tick(w_tick),
    .i_tgt_we(w_tgt_we[2]), .i_tgt_d(wbs_dat_i[3:0]),
    .o_tgt(w_tgt2), .o_cur(w_cur2), .o_trim(trim2_o),
    .o_busy(w_busy[2]), .o_done(w_done[2])
  );

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign busy_o    = w_busy;
  assign irq_o     = r_irq;

endmodule

// File: tb/tb_ldo_trim_ctrl.sv
// Testbench for ldo_trim_ctrl: bus expectations go into a queue that a
// monitor drains on every ack; trim/busy/irq behaviour is checked directly.
module tb_ldo_trim_ctrl;
  import ldo_trim_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'd0, dat_i = 32'd0;
  logic [31:0] dat_o;
  logic        ack;
  logic [15:0] trim0, trim1, trim2;
  logic [2:0]  busy;
  logic        irq;

  int          n_pass = 0;
  int          n_total = 0;
  int          bad_oh = 0;
  logic [31:0] exp_q[$];
  logic        prev_ack = 1'b0;

  ldo_trim_ctrl #(.BASE_ADR(BASE), .DIV_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i),
    .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .trim0_o(trim0), .trim1_o(trim1), .trim2_o(trim2),
    .busy_o(busy), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every ack pops one expectation; acks must never be back to back
  always @(negedge clk) begin
    if (rst) begin
      prev_ack <= 1'b0;
    end else begin
      if (ack) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_ack: got ack with data 0x%08h, expected no ack", dat_o);
        end else begin
          chk("ack_data", dat_o, exp_q.pop_front());
        end
        if (prev_ack) begin
          n_total++;
          $display("FAIL ack_b2b: got ack in two consecutive cycles, expected an idle cycle");
        end
      end else if (dat_o !== 32'd0) begin
        n_total++;
        $display("FAIL dat_idle: got 0x%08h outside ack, expected 0x00000000", dat_o);
      end
      prev_ack <= ack;
    end
  end

  // Trim buses must always be one-hot
  always @(negedge clk) begin
    if (!$onehot(trim0) || !$onehot(trim1) || !$onehot(trim2)) bad_oh++;
  end

  function automatic logic [15:0] trim_of(input int ch);
    case (ch)
      0:       return trim0;
      1:       return trim1;
      default: return trim2;
    endcase
  endfunction

  // Called at a negedge; drives the cycle now and returns at a negedge
  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [31:0] exp_rd, input bit exp_ack);
    bit got;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    if (exp_ack) exp_q.push_back(w ? 32'd0 : exp_rd);
    got = 1'b0;
    for (int i = 0; i < 3 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (exp_ack && !got) void'(exp_q.pop_back());
    n_total++;
    if (got == exp_ack) n_pass++;
    else $display("FAIL ack adr=0x%08h: got ack=%0d, expected ack=%0d", a, got, exp_ack);
  endtask

  task automatic wr(input logic [7:0] ofs, input logic [31:0] d, input logic [3:0] s);
    wb(1'b1, BASE | 32'(ofs), d, s, 32'd0, 1'b1);
  endtask

  task automatic rd(input logic [7:0] ofs, input logic [31:0] exp);
    wb(1'b0, BASE | 32'(ofs), 32'd0, 4'hF, exp, 1'b1);
  endtask

  task automatic wait_trim(input int ch, input logic [15:0] v, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (trim_of(ch) == v) found = 1'b1;
    end
    n_total++;
    if (found) n_pass++;
    else $display("FAIL %s: got trim%0d=0x%04h after timeout, expected 0x%04h", name, ch, trim_of(ch), v);
  endtask

  task automatic wait_idle(input int ch, input string name);
    bit idle;
    idle = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 100 && !idle; i++) begin
      if (!busy[ch]) idle = 1'b1;
      else @(negedge clk);
    end
    n_total++;
    if (idle) n_pass++;
    else $display("FAIL %s: got busy[%0d]=1 after timeout, expected 0", name, ch);
  endtask

  initial begin
    logic [15:0] steps[3];
    int          t_step[3];
    int          nstep;
    int          n_ack;
    logic [15:0] prev;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_trim0", 32'(trim0), 32'h0040);
    chk("rst_trim1", 32'(trim1), 32'h0100);
    chk("rst_trim2", 32'(trim2), 32'h0400);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_busy", 32'(busy), 32'd0);
    rd(OFS_STATUS, 32'h0000_0A86);
    rd(OFS_CTRL, 32'h0000_00FF);
    rd(OFS_TGT1, 32'd8);

    // Bus corner cases
    wr(OFS_TGT0, 32'h0000_000F, 4'b0000);
    rd(OFS_TGT0, 32'd6);
    wr(OFS_TGT2, 32'hFFFF_FFFA, 4'hF);
    rd(OFS_TGT2, 32'h0000_000A);
    rd(8'h20, 32'd0);
    wr(8'h20, 32'hFFFF_FFFF, 4'hF);
    rd(OFS_STATUS, 32'h0000_0A86);
    wb(1'b0, 32'h4000_0000, 32'd0, 4'hF, 32'd0, 1'b0);

    // Back-to-back strobes: acks on alternate cycles only
    repeat (3) exp_q.push_back(32'd6);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'(OFS_TGT0); sel = 4'hF;
    n_ack = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack) n_ack++;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("b2b_acks", 32'(n_ack), 32'd3);

    // Partial CTRL write: only the low byte changes, giving DIV=3
    wr(OFS_CTRL, 32'h0001_0203, 4'b0001);
    rd(OFS_CTRL, 32'h0000_0003);

    // Ramp up 6 -> 9, one step every 4 cycles
    wr(OFS_TGT0, 32'd9, 4'b0001);
    prev = trim0;
    nstep = 0;
    for (int i = 0; i < 80 && nstep < 3; i++) begin
      @(negedge clk);
      if (trim0 != prev) begin
        steps[nstep] = trim0;
        t_step[nstep] = i;
        nstep++;
        prev = trim0;
      end
    end
    chk("up_nsteps", 32'(nstep), 32'd3);
    if (nstep == 3) begin
      chk("up_step0", 32'(steps[0]), 32'h0080);
      chk("up_step1", 32'(steps[1]), 32'h0100);
      chk("up_step2", 32'(steps[2]), 32'h0200);
      chk("up_gap1", 32'(t_step[1] - t_step[0]), 32'd4);
      chk("up_gap2", 32'(t_step[2] - t_step[1]), 32'd4);
    end
    chk("up_busy_last", 32'(busy[0]), 32'd1);
    @(negedge clk);
    chk("up_busy_drop", 32'(busy[0]), 32'd0);
    rd(OFS_IRQST, 32'h0000_0001);
    wr(OFS_IRQST, 32'h0000_0001, 4'b0001);
    rd(OFS_IRQST, 32'h0000_0000);

    // Retarget: ramp 6 -> 12, at 8 retarget to 7
    wr(OFS_TGT0, 32'd6, 4'b0001);
    wait_idle(0, "down_idle");
    wr(OFS_IRQST, 32'h0000_0007, 4'b0001);
    wr(OFS_TGT0, 32'd12, 4'b0001);
    wait_trim(0, 16'h0100, "rt_reach8");
    wr(OFS_TGT0, 32'd7, 4'b0001);
    for (int i = 0; i < 20 && trim0 == 16'h0100; i++) @(negedge clk);
    chk("rt_next", 32'(trim0), 32'h0080);
    @(negedge clk);
    chk("rt_busy_drop", 32'(busy[0]), 32'd0);
    rd(OFS_IRQST, 32'h0000_0001);
    wr(OFS_IRQST, 32'h0000_0001, 4'b0001);

    // Interrupt enable, set and W1C
    wr(OFS_CTRL, 32'h0001_0003, 4'hF);
    rd(OFS_CTRL, 32'h0001_0003);
    chk("irq_idle", 32'(irq), 32'd0);
    wr(OFS_TGT0, 32'd8, 4'b0001);
    wait_idle(0, "irq_idle_wait");
    chk("irq_set", 32'(irq), 32'd1);
    wr(OFS_IRQST, 32'h0000_0001, 4'b0001);
    chk("irq_clr", 32'(irq), 32'd0);

    // W1C landing on the same edge as the done transition: set wins
    wr(OFS_TGT0, 32'd9, 4'b0001);
    wait_trim(0, 16'h0200, "coin_reach9");
    wr(OFS_IRQST, 32'h0000_0001, 4'b0001);
    chk("coin_busy", 32'(busy[0]), 32'd0);
    chk("coin_irq", 32'(irq), 32'd1);
    rd(OFS_IRQST, 32'h0000_0001);

    // Asynchronous reset mid-ramp with an ack outstanding
    wr(OFS_TGT1, 32'd15, 4'b0001);
    wait_trim(1, 16'h1000, "ar_reach12");
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'(OFS_STATUS); sel = 4'hF;
    @(posedge clk);
    #2;
    chk("ar_ack_pending", 32'(ack), 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_trim1", 32'(trim1), 32'h0100);
    chk("ar_trim0", 32'(trim0), 32'h0040);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_ack", 32'(ack), 32'd0);
    chk("ar_irq", 32'(irq), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    rd(OFS_STATUS, 32'h0000_0A86);

    // Drain
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("onehot", 32'(bad_oh), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ldo_trim_ctrl.md
LDO_TRIM_CTRL -- requirements
Module: ldo_trim_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADR, 32'h3000_0000, Wishbone base address; bits [31:8] are compared against wbs_adr_i[31:8].
REQ-002 SHALL have parameter DIV_W, 16, width of the ramp prescaler register.
REQ-003 SHALL have port wb_clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic cycle, strobe and write-enable.
REQ-006 SHALL have ports wbs_sel_i  input  4, wbs_adr_i  input  32, wbs_dat_i  input  32  byte selects, address and write data.
REQ-007 SHALL have ports wbs_dat_o  output  32, wbs_ack_o  output  1  read data and acknowledge.
REQ-008 SHALL have ports trim0_o, trim1_o, trim2_o  output  16 each  one-hot trim buses, one per LDO channel.
REQ-009 SHALL have ports busy_o  output  3  per-channel ramp-in-progress, and irq_o  output  1  ramp-done interrupt.

Function
REQ-010 Each channel SHALL hold a 4-bit target index TGTn and a 4-bit current index CURn, and drive trimn_o = 1 << CURn, which is always exactly one-hot.
REQ-011 Register map, offset = wbs_adr_i[7:0]:
- 0x00/0x04/0x08: TGT0/1/2 in bits [3:0], RW.
- 0x0C: STATUS, RO = {CUR2, CUR1, CUR0} in bits [11:0] and busy in bits [14:12].
- 0x10: CTRL, RW = DIV in bits [DIV_W-1:0] and irq-enable in bit 16.
- 0x14: IRQST, W1C, bits [2:0] per channel.
REQ-012 Bus access:
- wbs_ack_o SHALL pulse high for exactly one cycle, one cycle after cyc&stb is sampled high with an address match, and SHALL stay low in the cycle after an ack.
- Read data SHALL be valid in the ack cycle and 0 otherwise.
REQ-013 A write SHALL update only the bytes whose wbs_sel_i bit is set. Upper bits of TGT writes SHALL be ignored. Unmapped offsets SHALL ack, read 0 and ignore writes. A non-matching base SHALL not ack.
REQ-014 Prescaler:
- A free-running counter SHALL produce a one-cycle tick every DIV+1 cycles; DIV=0 gives a tick every cycle.
- Writing CTRL SHALL restart the counter at 0.
REQ-015 Per-channel FSM:
- IDLE to RAMP when CURn != TGTn.
- In RAMP, on each tick, CURn steps one position toward TGTn (+1 or -1, never skipping, never wrapping 15<->0).
- RAMP to IDLE in the cycle after CURn == TGTn; in that same transition IRQST bit n is set.
REQ-016 busy_o[n] SHALL be 1 exactly while channel n is in RAMP.
REQ-017 A TGTn write during RAMP SHALL retarget: the step direction is recomputed at the next tick. If the new TGTn equals CURn, the channel returns to IDLE and its IRQST bit is set.
REQ-018 If an IRQST bit is set by hardware and cleared by W1C in the same cycle, set SHALL win.
REQ-019 irq_o SHALL equal irq-enable AND (|IRQST), registered with no additional latency beyond the flop.
REQ-020 All three channels SHALL ramp independently on the shared tick.

Reset
REQ-021 While wb_rst_i is high, outputs SHALL immediately take these values:
- TGT0=CUR0=6, TGT1=CUR1=8, TGT2=CUR2=10, so trim0_o=16'h0040, trim1_o=16'h0100, trim2_o=16'h0400.
- DIV=0x00FF, irq-enable=0, IRQST=0, busy_o=0, irq_o=0, wbs_ack_o=0, wbs_dat_o=0, prescaler=0, all FSMs in IDLE.
REQ-022 Reset asserted mid-ramp SHALL return the trim outputs to the defaults without any intermediate code, and SHALL drop any pending ack.

Structure
REQ-023 A shared package ldo_trim_pkg SHALL hold the register offsets, reset indices (6, 8, 10), the reset DIV value and the FSM state enum.
REQ-024 The per-channel index/FSM/one-hot decode SHALL be one sub-module, ldo_trim_chan, instantiated three times. Bus decode and the prescaler SHALL stay in the top level.

Verification
REQ-025 Reset release: trim0/1/2_o = 0x0040/0x0100/0x0400, busy_o=0; a STATUS read returns 0x0000_0A86.
REQ-026 Ramp up: DIV=3, write TGT0=9 -> trim0_o steps 0x0080, 0x0100, 0x0200, one step every 4 cycles; busy_o[0] then drops; IRQST[0] is set.
REQ-027 Retarget: during a ramp 6->12, at CUR0=8 write TGT0=7 -> next step goes to 7, then busy drops; trim0_o is never multi-hot or zero.
REQ-028 Bus: write with sel=4'b0000 -> ack, no change; read 0x20 -> ack, data 0; address 0x4000_0000 -> no ack; back-to-back cyc/stb -> ack never high in two consecutive cycles.
REQ-029 IRQ: irq-enable=1, channel done -> irq_o=1; W1C 0x1 -> irq_o=0; a W1C coinciding with a done keeps the bit set.
REQ-030 Async reset mid-ramp (CUR1=12) -> trim1_o=0x0100 in the same cycle, busy_o=0, no ack.
